// File: rtl/redmule_tcdm_responder.sv
// Fixed-latency multi-port TCDM slave model with a shared word memory and
// LFSR-driven grant stalls, used as the memory side of the RedMulE HCI ports.
module redmule_tcdm_responder #(
  parameter int          MP    = 4,
  parameter int          PW    = 32,
  parameter int          AW    = 32,
  parameter int          DEPTH = 1024,
  parameter int          LAT   = 1,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     stall_en_i,
  input  logic [MP-1:0]            tcdm_req_i,
  output logic [MP-1:0]            tcdm_gnt_o,
  input  logic [MP-1:0][AW-1:0]    tcdm_add_i,
  input  logic [MP-1:0]            tcdm_wen_i,
  input  logic [MP-1:0][PW/8-1:0]  tcdm_be_i,
  input  logic [MP-1:0][PW-1:0]    tcdm_data_i,
  output logic [MP-1:0][PW-1:0]    tcdm_r_data_o,
  output logic [MP-1:0]            tcdm_r_valid_o,
  output logic                     tcdm_r_opc_o,
  output logic                     tcdm_r_user_o,
  output logic [31:0]              n_acc_o,
  output logic [31:0]              n_stall_o
);

  localparam int BEW  = PW / 8;
  localparam int OFFW = $clog2(BEW);
  localparam int IW   = $clog2(DEPTH);

  logic [15:0]               lfsr_q;
  logic [MP-1:0]             gnt;
  logic [MP-1:0]             hs;
  logic [BEW-1:0][7:0]       mem [DEPTH];
  logic [MP-1:0]             vld_p   [LAT];
  logic [MP-1:0][PW-1:0]     rdata_p [LAT];
  logic [31:0]               n_acc_q;
  logic [31:0]               n_stall_q;
  logic                      unused_addr_bits;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] a);
    return a[IW+OFFW-1:OFFW];
  endfunction

  function automatic logic [31:0] popcount(input logic [MP-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < MP; i++) c = c + 32'(v[i]);
    return c;
  endfunction

  // Upper address bits and the byte offset are deliberately ignored.
  assign unused_addr_bits = ^tcdm_add_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_step(lfsr_q);
  end

  // Grant is held low while in reset so every output reads 0 there.
  always_comb begin
    gnt = '0;
    for (int p = 0; p < MP; p++) begin
      gnt[p] = rst_ni & tcdm_req_i[p] & (~stall_en_i | ~lfsr_q[4'(p % 16)]);
    end
  end

  assign hs         = tcdm_req_i & gnt;
  assign tcdm_gnt_o = gnt;

  // Later NBAs override earlier ones, so the highest port wins per byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int p = 0; p < MP; p++) begin
        if (hs[p] && !tcdm_wen_i[p]) begin
          for (int b = 0; b < BEW; b++) begin
            if (tcdm_be_i[p][b]) mem[word_idx(tcdm_add_i[p])][b] <= tcdm_data_i[p][8*b +: 8];
          end
        end
      end
    end
  end

  // Stage p0: capture the pre-write word at the handshake edge; p1..: delay line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < LAT; s++) begin
        vld_p[s]   <= '0;
        rdata_p[s] <= '0;
      end
    end else begin
      vld_p[0] <= hs;
      for (int p = 0; p < MP; p++) begin
        rdata_p[0][p] <= (hs[p] && tcdm_wen_i[p]) ? PW'(mem[word_idx(tcdm_add_i[p])]) : '0;
      end
      for (int s = 1; s < LAT; s++) begin
        vld_p[s]   <= vld_p[s-1];
        rdata_p[s] <= rdata_p[s-1];
      end
    end
  end

  assign tcdm_r_valid_o = vld_p[LAT-1];
  assign tcdm_r_data_o  = rdata_p[LAT-1];
  assign tcdm_r_opc_o   = 1'b0;
  assign tcdm_r_user_o  = 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_acc_q   <= '0;
      n_stall_q <= '0;
    end else begin
      n_acc_q   <= n_acc_q + popcount(hs);
      n_stall_q <= n_stall_q + popcount(tcdm_req_i & ~gnt);
    end
  end

  assign n_acc_o   = n_acc_q;
  assign n_stall_o = n_stall_q;

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
// Scoreboard bench: directed TCDM traffic on a LAT=1 instance and a LAT=3 instance.
module tb_redmule_tcdm_responder;

  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    logic [31:0] d;
    int          due;
  } resp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;

  // LAT=1 instance signals
  logic             rst_n = 1'b0;
  logic             stall_en = 1'b0;
  logic [3:0]       req = '0, gnt, wen = '0, rvalid;
  logic [3:0][31:0] add = '0, wdata = '0, rdata, exp_d = '0;
  logic [3:0][3:0]  be = '0;
  logic             opc, user;
  logic [31:0]      n_acc, n_stall;

  // LAT=3 instance signals
  logic             rst3_n = 1'b0;
  logic [3:0]       req3 = '0, gnt3, wen3 = '0, rvalid3;
  logic [3:0][31:0] add3 = '0, wdata3 = '0, rdata3, exp_d3 = '0;
  logic [3:0][3:0]  be3 = '0;
  logic             opc3, user3;
  logic [31:0]      n_acc3, n_stall3;

  logic [15:0] lfsr_m;
  resp_t       sbq  [4][$];
  resp_t       sbq3 [4][$];

  redmule_tcdm_responder #(.MP(4), .PW(32), .AW(32), .DEPTH(1024), .LAT(1), .SEED(SEED)) dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_en_i(stall_en),
    .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_data_o(rdata), .tcdm_r_valid_o(rvalid),
    .tcdm_r_opc_o(opc), .tcdm_r_user_o(user), .n_acc_o(n_acc), .n_stall_o(n_stall)
  );

  redmule_tcdm_responder #(.MP(4), .PW(32), .AW(32), .DEPTH(1024), .LAT(3), .SEED(SEED)) dut3 (
    .clk_i(clk), .rst_ni(rst3_n), .stall_en_i(1'b0),
    .tcdm_req_i(req3), .tcdm_gnt_o(gnt3), .tcdm_add_i(add3), .tcdm_wen_i(wen3),
    .tcdm_be_i(be3), .tcdm_data_i(wdata3), .tcdm_r_data_o(rdata3), .tcdm_r_valid_o(rvalid3),
    .tcdm_r_opc_o(opc3), .tcdm_r_user_o(user3), .n_acc_o(n_acc3), .n_stall_o(n_stall3)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference Galois LFSR, taps 0xB400
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        lfsr_m <= SEED;
    else if (lfsr_m[0]) lfsr_m <= (lfsr_m >> 1) ^ 16'hB400;
    else               lfsr_m <= lfsr_m >> 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req_v, cyc);
    end
  endtask

  // Monitor for the LAT=1 instance: pop before push so queue order holds.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n) begin
      for (int p = 0; p < 4; p++) begin
        if (rvalid[p]) begin
          if (sbq[p].size() == 0) begin
            chk($sformatf("unexpected_rvalid_p%0d", p), 32'(rvalid[p]), 32'd0);
          end else begin
            e = sbq[p].pop_front();
            chk($sformatf("rdata_p%0d", p), rdata[p], e.d);
            chk($sformatf("latency_p%0d", p), 32'(cyc), 32'(e.due));
          end
        end else begin
          chk($sformatf("rdata_idle_p%0d", p), rdata[p], 32'd0);
        end
        chk($sformatf("gnt_p%0d", p), 32'(gnt[p]),
            32'(stall_en ? (req[p] & ~lfsr_m[p % 16]) : req[p]));
        if (req[p] && gnt[p]) begin
          sbq[p].push_back('{d: exp_d[p], due: cyc + 1});
          hs_cnt++;
        end
      end
    end
  end

  // Monitor for the LAT=3 instance; reset drops anything in flight.
  always @(negedge clk) begin
    resp_t e;
    if (!rst3_n) begin
      for (int p = 0; p < 4; p++) sbq3[p].delete();
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (rvalid3[p]) begin
          if (sbq3[p].size() == 0) begin
            chk($sformatf("lat3_unexpected_rvalid_p%0d", p), 32'(rvalid3[p]), 32'd0);
          end else begin
            e = sbq3[p].pop_front();
            chk($sformatf("lat3_rdata_p%0d", p), rdata3[p], e.d);
            chk($sformatf("lat3_latency_p%0d", p), 32'(cyc), 32'(e.due));
          end
        end
        if (req3[p] && gnt3[p]) sbq3[p].push_back('{d: exp_d3[p], due: cyc + 3});
      end
    end
  end

  task automatic issue(input int p, input logic rd, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] e);
    add[p] = a; wen[p] = rd; wdata[p] = d; be[p] = b; exp_d[p] = e; req[p] = 1'b1;
  endtask

  task automatic issue3(input int p, input logic rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] e);
    add3[p] = a; wen3[p] = rd; wdata3[p] = d; be3[p] = b; exp_d3[p] = e; req3[p] = 1'b1;
  endtask

  // Hold each request until granted, bounded by a cycle budget.
  task automatic run(input bit d3, input int budget);
    logic [3:0] done;
    int n = 0;
    while (((d3 ? req3 : req) != 4'd0) && (n < budget)) begin
      @(negedge clk);
      done = d3 ? (req3 & gnt3) : (req & gnt);
      @(posedge clk); #1;
      if (d3) req3 = req3 & ~done;
      else    req  = req & ~done;
      n++;
    end
    if ((d3 ? req3 : req) != 4'd0) begin
      chk("grant_timeout", 32'(d3 ? req3 : req), 32'd0);
      req = '0; req3 = '0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int base_sum, base_acc, base_stall, base_hs;
    // Reset: outputs must be 0 even with requests applied
    req = 4'hF;
    idle(3);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata[0] | rdata[1] | rdata[2] | rdata[3], 32'd0);
    chk("rst_n_acc", n_acc, 32'd0);
    chk("rst_n_stall", n_stall, 32'd0);
    chk("rst_opc_user", 32'({opc, user}), 32'd0);
    @(posedge clk); #1;
    req = '0;
    rst_n = 1'b1;
    idle(1);

    // Write then read back
    issue(0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0);
    run(1'b0, 20);
    issue(0, 1'b1, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF);
    run(1'b0, 20);
    idle(3);
    @(negedge clk);
    chk("n_acc_after_rw", n_acc, 32'd2);
    @(posedge clk); #1;

    // Partial write: bytes 0 and 2 from the second write
    issue(1, 1'b0, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0);
    run(1'b0, 20);
    issue(1, 1'b0, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0);
    run(1'b0, 20);
    issue(1, 1'b1, 32'h0000_0020, 32'h0, 4'hF, 32'h11BB_33DD);
    run(1'b0, 20);

    // Same-cycle collision: read sees old value, port3 wins the write
    issue(1, 1'b0, 32'h0000_0040, 32'h0000_0001, 4'hF, 32'h0);
    issue(3, 1'b0, 32'h0000_0040, 32'h0000_0003, 4'hF, 32'h0);
    issue(2, 1'b1, 32'h0000_0040, 32'h0, 4'hF, 32'h0);
    run(1'b0, 20);
    issue(0, 1'b1, 32'h0000_0040, 32'h0, 4'hF, 32'h0000_0003);
    run(1'b0, 20);

    // Bytes enabled only by the lower port keep its data
    issue(0, 1'b0, 32'h0000_0080, 32'h1111_1111, 4'hF, 32'h0);
    issue(2, 1'b0, 32'h0000_0083, 32'h0000_2222, 4'h3, 32'h0);
    run(1'b0, 20);
    issue(3, 1'b1, 32'h0000_0080, 32'h0, 4'h0, 32'h1111_2222);
    run(1'b0, 20);

    // Address wrap modulo DEPTH words
    issue(2, 1'b0, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'h0);
    run(1'b0, 20);
    issue(2, 1'b1, 32'h0000_0000, 32'h0, 4'hF, 32'hCAFE_F00D);
    run(1'b0, 20);
    idle(3);

    // Random stalls: all ports request continuously for 200 cycles
    base_sum   = int'(n_acc + n_stall);
    base_acc   = int'(n_acc);
    base_stall = int'(n_stall);
    base_hs    = hs_cnt;
    stall_en = 1'b1;
    for (int p = 0; p < 4; p++) issue(p, 1'b1, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF);
    idle(200);
    req = '0;
    stall_en = 1'b0;
    idle(3);
    @(negedge clk);
    chk("acc_plus_stall", 32'(int'(n_acc + n_stall) - base_sum), 32'd800);
    chk("acc_vs_handshakes", 32'(int'(n_acc) - base_acc), 32'(hs_cnt - base_hs));
    chk("stalls_seen", 32'((int'(n_stall) - base_stall) > 0), 32'd1);
    for (int p = 0; p < 4; p++) chk($sformatf("sb_empty_p%0d", p), 32'(sbq[p].size()), 32'd0);
    @(posedge clk); #1;

    // LAT=3 instance: normal round trip
    rst3_n = 1'b1;
    idle(1);
    issue3(1, 1'b0, 32'h0000_0008, 32'h5A5A_5A5A, 4'hF, 32'h0);
    run(1'b1, 20);
    issue3(1, 1'b1, 32'h0000_0008, 32'h0, 4'hF, 32'h5A5A_5A5A);
    run(1'b1, 20);
    idle(5);
    for (int p = 0; p < 4; p++) chk($sformatf("lat3_sb_empty_p%0d", p), 32'(sbq3[p].size()), 32'd0);

    // Reset one cycle after a read handshake drops the response
    issue3(0, 1'b1, 32'h0000_0008, 32'h0, 4'hF, 32'h5A5A_5A5A);
    run(1'b1, 20);
    @(negedge clk);
    chk("lat3_n_acc_before_rst", n_acc3, 32'd3);
    @(posedge clk); #1;
    rst3_n = 1'b0;
    req3 = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("lat3_rst_rvalid", 32'(rvalid3), 32'd0);
      chk("lat3_rst_rdata", rdata3[0] | rdata3[1] | rdata3[2] | rdata3[3], 32'd0);
      chk("lat3_rst_gnt", 32'(gnt3), 32'd0);
      chk("lat3_rst_counters", n_acc3 | n_stall3, 32'd0);
    end
    @(posedge clk); #1;
    req3 = '0;
    rst3_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("lat3_post_rst_rvalid", 32'(rvalid3), 32'd0);
    end
    chk("lat3_post_rst_n_acc", n_acc3, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/redmule_tcdm_responder.md
Name: redmule_tcdm_responder

Overview:
- Single-cycle-grant, fixed-latency TCDM slave model that answers the MP narrow TCDM master ports driven out of the RedMulE wrapper.
- Holds a shared word-addressed memory.
- Applies per-port pseudo-random grant stalls to exercise the wrapper's AND-ed gnt/r_valid reduction.
- Used in the standalone RedMulE testbench and the FPGA emulation harness as the memory side of the HCI interface.

Parameters:
- MP, 4, number of narrow TCDM ports.
- PW, 32, port data width in bits (BE width PW/8).
- AW, 32, address width.
- DEPTH, 1024, memory depth in PW-bit words (power of two).
- LAT, 1, read/write response latency in cycles after handshake (1..4).
- SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- stall_en_i, in, 1, enable pseudo-random grant stalls.
- tcdm_req_i, in, MP, per-port request.
- tcdm_gnt_o, out, MP, per-port grant.
- tcdm_add_i, in, MP x AW, byte address.
- tcdm_wen_i, in, MP, 1=read, 0=write.
- tcdm_be_i, in, MP x PW/8, byte enables.
- tcdm_data_i, in, MP x PW, write data.
- tcdm_r_data_o, out, MP x PW, read data.
- tcdm_r_valid_o, out, MP, response valid.
- tcdm_r_opc_o, out, 1, error flag, tied 0.
- tcdm_r_user_o, out, 1, tied 0.
- n_acc_o, out, 32, count of accepted transactions, all ports.
- n_stall_o, out, 32, count of port-cycles with req=1 and gnt=0.

Behaviour:
- Reset (async, rst_ni=0): memory cleared to 0; LFSR=SEED; response pipeline cleared; all outputs 0; counters 0. Reset mid-transaction drops in-flight responses; no r_valid after release for pre-reset requests.
- LFSR: 16-bit Galois, taps 0xB400; advances every cycle after reset.
- Grant is combinational:
  - stall_en_i=1: gnt[p] = req[p] & ~lfsr[p % 16].
  - stall_en_i=0: gnt[p] = req[p].
- Handshake = req & gnt in the same cycle. Requests are not queued. A stalled master holds req/add/wen/be/data until granted.
- Word index = add[log2(DEPTH)+log2(PW/8)-1 : log2(PW/8)]. Upper bits are ignored, so addresses wrap modulo DEPTH words. Low byte-offset bits are ignored.
- Write on handshake: bytes with be=1 updated at the clock edge; bytes with be=0 keep their value.
- Read on handshake: word captured at the same edge (pre-write value) into the per-port response pipeline.
- Response: r_valid[p] is asserted exactly LAT cycles after the handshake edge, for one cycle per transaction, for reads and writes alike.
  - r_data holds the read word for reads, 0 for writes.
  - r_data is 0 whenever r_valid=0.
- Back-to-back: one handshake per port per cycle, fully pipelined. There is no backpressure on responses.
- Simultaneous writes to the same word: higher port index wins per byte. Bytes enabled only by a lower port still take that port's data.
- Read and write to the same word in the same cycle (any ports): the read returns the old value.
- Counters:
  - n_acc_o += popcount(req & gnt) each cycle.
  - n_stall_o += popcount(req & ~gnt).
  - Both wrap at 2^32.
- No combinational path from any input to r_data_o/r_valid_o.

Test Plan:
- Reset, then stall_en=0. Port0 writes 0xDEADBEEF to 0x0010, be=0xF. Next cycle port0 reads 0x0010 → gnt same cycle, r_valid 1 cycle later (LAT=1), r_data=0xDEADBEEF; n_acc=2.
- Partial write: 0x11223344 to 0x0020, then 0xAABBCCDD with be=0x5, then read → 0x11BB33DD.
- Same-cycle collision: port1 writes 0x00000001 and port3 writes 0x00000003 to 0x0040 with be=0xF; port2 reads 0x0040 that cycle → port2 returns the old value 0. A following read returns 0x00000003.
- Wrap: write 0xCAFEF00D to 0x1000 (DEPTH=1024, PW=32); read 0x0000 → 0xCAFEF00D.
- Stalls: stall_en=1, all ports request continuously for 200 cycles.
  - gnt[p] matches the reference LFSR model bit p.
  - n_acc + n_stall = 800.
  - Every r_valid is exactly LAT cycles after its handshake.
- LAT=3, then reset asserted 1 cycle after a read handshake → r_valid stays 0 through and after reset; all outputs 0 during reset.
